// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 encodings, FSM state type and word geometry for the load/store unit
package lsu_pkg;
  localparam logic [2:0] F3_B = 3'b000;
  localparam logic [2:0] F3_H = 3'b001;
  localparam logic [2:0] F3_W = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam int WORD_BYTES = 4;
  typedef enum logic {IDLE, RMW_WR} lsu_state_t;
endpackage

// File: rtl/lsu_if.sv
// lsu_if: core request/response handshake plus data-memory port of the load/store unit
interface lsu_if;
  logic req_valid;
  logic req_ready;
  logic req_we;
  logic [2:0] req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic rsp_valid;
  logic [31:0] rsp_rdata;
  logic rsp_err;
  logic dm_rd_en;
  logic dm_wr_en;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  modport slave (
    input req_valid, req_we, req_funct3, req_addr, req_wdata, dm_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, dm_rd_en, dm_wr_en, dm_addr, dm_wdata
  );
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, dm_rdata,
    input req_ready, rsp_valid, rsp_rdata, rsp_err, dm_rd_en, dm_wr_en, dm_addr, dm_wdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: byte-lane extraction/extension for loads and lane merge for sub-word stores
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word,
  output logic        misalign
);
  logic [4:0] sh;
  logic [31:0] lane;
  logic [31:0] mask;
  logic [31:0] data;
  assign sh = {off, 3'b000};
  // shift the addressed lane down for loads and replicate store data into every lane for the merge
  always_comb begin
    lane = word >> sh;
    misalign = funct3[1:0] == 2'b01 ? off[0] : funct3[1:0] == 2'b10 ? |off : 1'b0;
    load_data = funct3 == F3_B  ? {{24{lane[7]}}, lane[7:0]} :
                funct3 == F3_BU ? {24'b0, lane[7:0]} :
                funct3 == F3_H  ? {{16{lane[15]}}, lane[15:0]} :
                funct3 == F3_HU ? {16'b0, lane[15:0]} : word;
    mask = funct3[1:0] == 2'b00 ? 32'h0000_00FF << sh :
           funct3[1:0] == 2'b01 ? 32'h0000_FFFF << sh : '1;
    data = funct3[1:0] == 2'b00 ? {4{wdata[7:0]}} :
           funct3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
    store_word = (word & ~mask) | (data & mask);
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: byte-addressed core requests to a word-only data memory, sub-word stores via read-modify-write
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input logic clk,
  input logic reset,
  lsu_if.slave bus
);
  lsu_state_t state, next_state;
  logic accept;
  logic legal;
  logic oor;
  logic misalign;
  logic err;
  logic rmw;
  logic [31:0] load_data;
  logic [31:0] store_word;
  logic [31:0] word_idx;
  logic [31:0] lat_idx;
  logic [31:0] lat_data;
  logic rsp_valid;
  logic rsp_err;
  logic [31:0] rsp_rdata;

  lsu_lane_align u_align (
    .funct3(bus.req_funct3),
    .off(bus.req_addr[1:0]),
    .word(bus.dm_rdata),
    .wdata(bus.req_wdata),
    .load_data(load_data),
    .store_word(store_word),
    .misalign(misalign)
  );

  assign word_idx = {2'b00, bus.req_addr[31:2]};
  assign legal = bus.req_we ? (bus.req_funct3 == F3_B || bus.req_funct3 == F3_H || bus.req_funct3 == F3_W)
                            : (bus.req_funct3 == F3_B || bus.req_funct3 == F3_H || bus.req_funct3 == F3_W ||
                               bus.req_funct3 == F3_BU || bus.req_funct3 == F3_HU);
  assign oor = word_idx >= 32'(DEPTH_WORDS);
  assign err = ~legal | misalign | oor;
  assign rmw = bus.req_we & (bus.req_funct3[1:0] != 2'b10);
  assign bus.req_ready = reset & (state == IDLE);
  assign accept = bus.req_valid & bus.req_ready;
  assign bus.dm_rd_en = reset & accept & ~err & (~bus.req_we | rmw);
  assign bus.dm_wr_en = reset & ((state == RMW_WR) | (accept & ~err & bus.req_we & ~rmw));
  assign bus.dm_addr = state == RMW_WR ? lat_idx : word_idx;
  assign bus.dm_wdata = state == RMW_WR ? lat_data : bus.req_wdata;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_err = rsp_err;
  assign bus.rsp_rdata = rsp_rdata;

  // sub-word stores spend one extra cycle writing the merged word back
  always_comb begin
    next_state = IDLE;
    next_state = state == RMW_WR ? IDLE : (accept & ~err & rmw) ? RMW_WR : IDLE;
  end

  // state, response pulse and the latched RMW index/word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rsp_rdata <= '0;
      lat_idx <= '0;
      lat_data <= '0;
    end else begin
      state <= next_state;
      rsp_valid <= (accept & (err | ~rmw)) | (state == RMW_WR);
      rsp_err <= accept & err;
      rsp_rdata <= (accept & ~err & ~bus.req_we) ? load_data : '0;
      if (accept & ~err & rmw) begin
        lat_idx <= word_idx;
        lat_data <= store_word;
      end
    end
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly upstream of the word-addressed data memory in the single-cycle datapath. It converts core load/store requests (byte address, funct3 size/sign) into word-indexed memory accesses.
- Loads: extracts and sign/zero-extends the addressed byte, half or word.
- Stores: the memory has no byte strobes, so SB/SH are done as read-modify-write over two cycles. SW is written directly.
- Handshake stalls the core during RMW and reports misaligned, out-of-range or illegal requests.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the data memory; a word index >= DEPTH_WORDS is out of range.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  core request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I load/store funct3.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low byte/half is used for SB/SH.
- rsp_valid  out  1  one-cycle pulse: request completed.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  qualified by rsp_valid: misaligned, out-of-range or illegal funct3.
- dm_rd_en  out  1  memory read enable.
- dm_wr_en  out  1  memory write enable; memory writes on falling edge.
- dm_addr  out  32  word index = {2'b0, req_addr[31:2]}, or the latched index during RMW.
- dm_wdata  out  32  word to write.
- dm_rdata  in  32  combinational memory read data.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0; latched address/data cleared.
  - req_ready=0, dm_wr_en=0, dm_rd_en=0 while reset is asserted.
- States: IDLE, RMW_WR.
- IDLE:
  - req_ready=1.
  - Accept = req_valid & req_ready.
  - Memory signals are combinational from the request in the accept cycle.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is illegal.
- Error check on accept:
  - Halfword requires addr[0]=0; word requires addr[1:0]=0.
  - addr[31:2] >= DEPTH_WORDS is an error.
  - On error: no dm_rd_en/dm_wr_en; next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0; stay in IDLE.
- Load accept:
  - dm_rd_en=1.
  - Selected lane from dm_rdata is shifted by addr[1:0] and extended (LB/LH sign, LBU/LHU zero).
  - Result registered into rsp_rdata; rsp_valid=1 the next cycle.
  - Latency 1, back-to-back throughput 1/cycle.
- SW accept:
  - dm_wr_en=1, dm_wdata=req_wdata in the same cycle.
  - rsp_valid pulses the next cycle with rsp_rdata=0.
  - Latency 1.
- SB/SH accept:
  - dm_rd_en=1; merged word registered: dm_rdata with the addressed lane replaced by req_wdata[7:0] or [15:0].
  - Word index is latched; go to RMW_WR.
- RMW_WR:
  - req_ready=0; dm_wr_en=1, dm_addr=latched index, dm_wdata=merged word.
  - Return to IDLE; rsp_valid pulses the following cycle.
  - SB/SH latency 2, throughput 1 per 2 cycles.
- req_valid is ignored when req_ready=0; the core must hold its request until accepted.
- rsp_valid is never high for two cycles from one request, and never high in the cycle after reset deasserts.
- Reset asserted in RMW_WR: the write is aborted (dm_wr_en forced 0) and no response is issued.
- A load at the same word immediately after an RMW sees the new data, because the write lands at the falling edge before the next rising edge.

Decomposition:
- Shared package lsu_pkg:
  - funct3 encodings as constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - state enum lsu_state_t {IDLE, RMW_WR}.
  - WORD_BYTES=4 constant.
- One natural combinational sub-module, lsu_lane_align:
  - Inputs: funct3, addr[1:0], word, store data.
  - Outputs: extended load data, merged store word, misalign flag.
  - Shared by the load and RMW paths.

Test Plan:
- Mem word 5 = 0x80FF_7F01; LB addr 0x16 -> rsp_rdata=0xFFFF_FFFF; LBU addr 0x17 -> 0x0000_0080; LH addr 0x16 -> 0xFFFF_80FF. Each response is 1 cycle after accept, with rsp_err=0.
- Word 3 = 0x1122_3344; SB addr 0x0D, wdata 0xAB -> req_ready low 1 cycle, word 3 = 0x1122_AB44, then rsp_valid. A following LW addr 0x0C returns 0x1122_AB44.
- SW addr 0x0E (misaligned) -> no dm_wr_en, word 3 unchanged, rsp_valid=1 with rsp_err=1. LW addr 0x1000 (index 1024) -> rsp_err=1.
- Back-to-back LW on 4 consecutive cycles -> 4 consecutive rsp_valid pulses, req_ready stays 1.
- reset driven low mid-cycle while in RMW_WR for SH addr 0x22 -> outputs zero immediately, word 8 unchanged, no rsp_valid after release.
- funct3=011 load -> rsp_err=1, dm_rd_en never asserted.
